// File: rtl/amp_trim_sequencer.sv
// Power-up, SAR offset-trim calibration and gain hand-over controller for the
// on-die differential amplifier. Comparator decisions use a 2-flop synchronised copy.
module amp_trim_sequencer #(
   parameter int TRIM_W   = 6,
   parameter int GAIN_W   = 3,
   parameter int SETTLE   = 8,
   parameter int PWR_WAIT = 64,
   parameter int GAIN_CAL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              cmp_async,
   input  logic              gain_we,
   input  logic [GAIN_W-1:0] gain_req,
   output logic              amp_en,
   output logic              in_short,
   output logic [TRIM_W-1:0] trim_code,
   output logic [GAIN_W-1:0] gain_code,
   output logic              busy,
   output logic              done,
   output logic              cal_err,
   output logic              out_valid
);

   localparam int CNT_MAX = (PWR_WAIT > SETTLE) ? PWR_WAIT : SETTLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

   localparam logic [CNT_W-1:0]  PWR_LAST   = CNT_W'(PWR_WAIT - 1);
   localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  BLANK_INIT = CNT_W'(SETTLE);
   localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(TRIM_W - 1);
   localparam logic [TRIM_W-1:0] TRIM_TOP   = TRIM_W'(1) << (TRIM_W - 1);
   localparam logic [GAIN_W-1:0] GAIN_CAL_C = GAIN_W'(GAIN_CAL);

   typedef enum logic [1:0] {ST_IDLE, ST_POWERUP, ST_SAR, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  blank_q;
   logic [IDX_W-1:0]  idx_q;
   logic [TRIM_W-1:0] trim_q;
   logic [TRIM_W-1:0] trim_sar;
   logic [TRIM_W-1:0] bit_mask;
   logic [GAIN_W-1:0] gain_st_q;
   logic              cmp_meta;
   logic              cmp_s;
   logic              done_q;
   logic              cal_err_q;
   logic              step_end;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      amp_en    = 1'b0;
      in_short  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      gain_code = gain_st_q;
      step_end  = (state_q == ST_SAR) && (cnt_q == STEP_LAST);
      // Trial code for the next step: resolve the current bit, then raise the next one.
      bit_mask  = TRIM_W'(1) << idx_q;
      trim_sar  = cmp_s ? (trim_q & ~bit_mask) : trim_q;
      trim_sar  = trim_sar | (bit_mask >> 1);
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_POWERUP;
         end
         ST_POWERUP: begin
            amp_en    = 1'b1;
            in_short  = 1'b1;
            busy      = 1'b1;
            gain_code = GAIN_CAL_C;
            if (stop)                   state_d = ST_IDLE;
            else if (cnt_q == PWR_LAST) state_d = ST_SAR;
         end
         ST_SAR: begin
            amp_en    = 1'b1;
            in_short  = 1'b1;
            busy      = 1'b1;
            gain_code = GAIN_CAL_C;
            if (stop)                             state_d = ST_IDLE;
            else if (step_end && (idx_q == '0))   state_d = ST_RUN;
         end
         ST_RUN: begin
            amp_en    = 1'b1;
            out_valid = (blank_q == '0);
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_POWERUP;
         end
         default: state_d = ST_IDLE;
      endcase
      trim_code = trim_q;
      done      = done_q;
      cal_err   = cal_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_meta  <= 1'b0;
         cmp_s     <= 1'b0;
         cnt_q     <= '0;
         blank_q   <= '0;
         idx_q     <= '0;
         trim_q    <= '0;
         gain_st_q <= '0;
         done_q    <= 1'b0;
         cal_err_q <= 1'b0;
      end else begin
         cmp_meta <= cmp_async;
         cmp_s    <= cmp_meta;
         done_q   <= 1'b0;
         if (gain_we) gain_st_q <= gain_req;

         if (((state_q == ST_POWERUP) || (state_q == ST_SAR)) &&
             (state_d == state_q) && !step_end)
            cnt_q <= cnt_q + 1'b1;
         else
            cnt_q <= '0;

         if ((state_d == ST_POWERUP) && (state_q != ST_POWERUP)) begin
            trim_q <= '0;
         end else if ((state_q == ST_POWERUP) && (state_d == ST_SAR)) begin
            trim_q <= TRIM_TOP;
            idx_q  <= IDX_TOP;
         end else if (step_end && (state_d != ST_IDLE)) begin
            trim_q <= trim_sar;
            idx_q  <= idx_q - 1'b1;
            if (state_d == ST_RUN) begin
               done_q    <= 1'b1;
               cal_err_q <= (trim_sar == '0) || (trim_sar == '1);
            end
         end

         // Blanking window restarts on every gain write that lands in RUN.
         if (state_d != ST_RUN)                        blank_q <= '0;
         else if ((state_q == ST_RUN) && gain_we)      blank_q <= BLANK_INIT;
         else if (blank_q != '0)                       blank_q <= blank_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_amp_trim_sequencer.sv
// Self-checking bench for amp_trim_sequencer: timeline-based reference model checked
// every cycle, plus directed literal checks on calibration results and blanking.
module tb_amp_trim_sequencer;

   localparam int TW = 6, GW = 3, ST = 8, PW = 64, GC = 0;
   localparam int CAL_LEN = PW + TW * ST;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, stop = 1'b0, gain_we = 1'b0;
   logic [GW-1:0] gain_req = '0;
   logic          cmp_async;
   logic          amp_en, in_short, busy, done, cal_err, out_valid;
   logic [TW-1:0] trim_code;
   logic [GW-1:0] gain_code;

   // Comparator model: 0 = threshold, 1 = tied high, 2 = tied low, 3 = random.
   int            cmp_mode = 3;
   logic [TW-1:0] thr = 6'h2B;
   logic          cmp_rnd = 1'b0;

   assign cmp_async = (cmp_mode == 0) ? (trim_code > thr) :
                      (cmp_mode == 1) ? 1'b1 :
                      (cmp_mode == 2) ? 1'b0 : cmp_rnd;

   amp_trim_sequencer #(.TRIM_W(TW), .GAIN_W(GW), .SETTLE(ST), .PWR_WAIT(PW), .GAIN_CAL(GC)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_async(cmp_async),
      .gain_we(gain_we), .gain_req(gain_req), .amp_en(amp_en), .in_short(in_short),
      .trim_code(trim_code), .gain_code(gain_code), .busy(busy), .done(done),
      .cal_err(cal_err), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 calibrating (age = cycles since start edge), 2 run.
   int            cyc = 0;
   bit            m_valid = 0;
   int            m_mode = 0;
   int            m_age = 0;
   logic [TW-1:0] m_trim = '0, m_final = '0;
   logic [GW-1:0] m_gain = '0;
   logic          m_err = 1'b0;
   int            m_blank_end = 0;
   int            m_done_cyc = -1;

   function automatic bit cmp_ref(input logic [TW-1:0] x);
      case (cmp_mode)
         0: return x > thr;
         1: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [TW-1:0] sar_result();
      logic [TW-1:0] res = '0;
      logic [TW-1:0] trial;
      for (int b = TW - 1; b >= 0; b--) begin
         trial = res | TW'(1 << b);
         if (!cmp_ref(trial)) res = trial;
      end
      return res;
   endfunction

   function automatic logic [TW-1:0] trim_at(input int a);
      int s, b, hi;
      if (a <= PW) return '0;
      s  = (a - PW - 1) / ST;
      b  = TW - 1 - s;
      hi = int'(m_final) & ~((1 << (b + 1)) - 1);
      return TW'(hi | (1 << b));
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_valid = 1; m_mode = 0; m_trim = '0; m_gain = '0; m_err = 1'b0;
         m_blank_end = 0; m_done_cyc = -1;
      end else if (m_valid) begin
         case (m_mode)
            0: if (start) begin m_mode = 1; m_age = 1; m_final = sar_result(); end
            1: begin
               if (stop) begin
                  m_trim = trim_at(m_age); m_mode = 0;
               end else begin
                  m_age++;
                  if (m_age > CAL_LEN) begin
                     m_mode = 2; m_trim = m_final; m_done_cyc = cyc; m_blank_end = 0;
                     m_err = (m_final == '0) || (m_final == '1);
                  end
               end
            end
            default: begin
               if (stop) m_mode = 0;
               else if (start) begin m_mode = 1; m_age = 1; m_final = sar_result(); end
               else if (gain_we) m_blank_end = cyc + ST;
            end
         endcase
         if (gain_we) m_gain = gain_req;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         int e_trim, e_gain;
         bit e_amp, e_short, e_busy, e_valid, e_done;
         e_amp = 0; e_short = 0; e_busy = 0; e_valid = 0; e_done = 0;
         e_trim = int'(m_trim); e_gain = int'(m_gain);
         if (m_mode == 1) begin
            e_amp = 1; e_short = 1; e_busy = 1; e_gain = GC; e_trim = int'(trim_at(m_age));
         end else if (m_mode == 2) begin
            e_amp = 1; e_valid = (cyc >= m_blank_end); e_done = (cyc == m_done_cyc);
         end
         chk("amp_en", int'(amp_en), int'(e_amp));
         chk("in_short", int'(in_short), int'(e_short));
         chk("busy", int'(busy), int'(e_busy));
         chk("trim_code", int'(trim_code), e_trim);
         chk("gain_code", int'(gain_code), e_gain);
         chk("done", int'(done), int'(e_done));
         chk("cal_err", int'(cal_err), int'(m_err));
         chk("out_valid", int'(out_valid), int'(e_valid));
      end
   end

   // Length of the most recent out_valid-low run while in RUN.
   int cur_run = 0, last_run = 0;
   always @(negedge clk) begin
      if (amp_en === 1'b1 && busy === 1'b0) begin
         if (!out_valid) cur_run++;
         else if (cur_run != 0) begin last_run = cur_run; cur_run = 0; end
      end else cur_run = 0;
   end

   task automatic run_cal(input int inj_at, output int nd);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nd = 0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("cal_in_short", int'(in_short), 1);
            chk("cal_busy", int'(busy), 1);
            chk("cal_trim0", int'(trim_code), 0);
         end
         if (n == inj_at) start = 1'b1;
         else if (n == inj_at + 1) start = 1'b0;
         if (done) begin nd = n; break; end
      end
   endtask

   initial begin
      int nd;
      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         start = 1'($urandom); stop = 1'($urandom); gain_we = 1'($urandom);
         gain_req = GW'($urandom); cmp_rnd = 1'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b0; start = 0; stop = 0; gain_we = 0; gain_req = '0; cmp_mode = 0;
      repeat (3) @(negedge clk);
      chk("idle_amp_en", int'(amp_en), 0);
      chk("idle_trim", int'(trim_code), 0);
      chk("idle_valid", int'(out_valid), 0);

      // Gain write in IDLE
      gain_req = 3'd3; gain_we = 1'b1;
      @(posedge clk); #1 gain_we = 1'b0;
      @(negedge clk);
      chk("idle_gain", int'(gain_code), 3);

      // Nominal calibration, with an ignored start during SAR
      thr = 6'h2B;
      run_cal(80, nd);
      chk("nom_latency", nd, 113);
      chk("nom_trim", int'(trim_code), 'h2B);
      chk("nom_err", int'(cal_err), 0);
      chk("nom_valid", int'(out_valid), 1);
      chk("nom_short", int'(in_short), 0);
      chk("nom_gain", int'(gain_code), 3);

      // Gain blanking, single then restarted window
      repeat (3) @(negedge clk);
      gain_req = 3'd5; gain_we = 1'b1;
      @(posedge clk); #1 gain_we = 1'b0;
      repeat (20) @(negedge clk);
      chk("blank_gain", int'(gain_code), 5);
      chk("blank_len8", last_run, 8);
      gain_we = 1'b1;
      @(posedge clk); #1 gain_we = 1'b0;
      repeat (3) @(posedge clk);
      #1 gain_we = 1'b1;
      @(posedge clk); #1 gain_we = 1'b0;
      repeat (25) @(negedge clk);
      chk("blank_len12", last_run, 12);

      // Rail errors
      cmp_mode = 1;
      run_cal(0, nd);
      chk("rail1_latency", nd, 113);
      chk("rail1_trim", int'(trim_code), 0);
      chk("rail1_err", int'(cal_err), 1);
      cmp_mode = 2;
      run_cal(0, nd);
      chk("rail0_trim", int'(trim_code), 'h3F);
      chk("rail0_err", int'(cal_err), 1);

      // Recalibration from RUN with a new target
      cmp_mode = 0; thr = 6'h2B;
      run_cal(0, nd);
      chk("pre_recal_trim", int'(trim_code), 'h2B);
      chk("pre_recal_err", int'(cal_err), 0);
      repeat (2) @(negedge clk);
      thr = 6'h11;
      run_cal(0, nd);
      chk("recal_latency", nd, 113);
      chk("recal_trim", int'(trim_code), 'h11);
      chk("recal_gain", int'(gain_code), 5);

      // Reset during SAR bit 3
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (84) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_sar_trim", int'(trim_code), 0);
      chk("rst_sar_busy", int'(busy), 0);
      chk("rst_sar_done", int'(done), 0);
      chk("rst_sar_amp", int'(amp_en), 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // Stop during POWERUP
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pwr_amp_on", int'(amp_en), 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_amp_en", int'(amp_en), 0);
      chk("stop_busy", int'(busy), 0);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
